// File: rtl/mux_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_seq_pkg
// Brief    : Shared types and helpers for the multiplexer sequencer: state
//            encodings and the sequence-table entry width.
//            Optional feature macro: MUX_SEQ_DWELL_EN (per-entry dwell storage).
// Revision : 1.0 - initial release
// ============================================================================
package mux_seq_pkg;

    // Sequencer states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

`ifdef MUX_SEQ_DWELL_EN
    localparam bit c_DWELL_EN = 1'b1;
`else
    localparam bit c_DWELL_EN = 1'b0;
`endif

    // Bits stored per table entry: the select, plus the dwell count when the
    // dwell feature is built in.
    function automatic int entry_width(input int sel_w, input int dwell_w);
        return sel_w + (c_DWELL_EN ? dwell_w : 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_seq_table.sv
`default_nettype none
// ============================================================================
// Module   : mux_seq_table
// Brief    : Sequence table. Synchronous write, asynchronous read on two
//            independent ports (dwell of the current entry, select of the
//            entry about to become current).
//            Optional feature macro: MUX_SEQ_DWELL_EN (stores dwell bits).
// Revision : 1.0 - initial release
// ============================================================================
module mux_seq_table
    import mux_seq_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8,
    parameter int DEPTH   = 8,
    parameter int IDX_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_we,
    input  logic [IDX_W-1:0]   i_waddr,
    input  logic [SEL_W-1:0]   i_wsel,
    input  logic [DWELL_W-1:0] i_wdwell,
    input  logic [IDX_W-1:0]   i_dwell_addr,
    input  logic [IDX_W-1:0]   i_sel_addr,
    output logic [DWELL_W-1:0] o_dwell,
    output logic [SEL_W-1:0]   o_sel
);

    localparam int c_ENTRY_W = entry_width(SEL_W, DWELL_W);

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_ENTRY_W-1:0] w_wdata;

`ifdef MUX_SEQ_DWELL_EN
    assign w_wdata = {i_wdwell, i_wsel};
    assign o_dwell = r_mem[i_dwell_addr][SEL_W +: DWELL_W];
`else
    // No dwell storage: every entry behaves as dwell 0.
    logic w_unused_dwell;
    assign w_wdata        = i_wsel;
    assign o_dwell        = '0;
    assign w_unused_dwell = ^{i_wdwell, i_dwell_addr};
`endif

    assign o_sel = r_mem[i_sel_addr][SEL_W-1:0];

    // Table storage: cleared on reset, one entry written per accepted write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                r_mem[i] <= '0;
            end else if (i_we && (i_waddr == IDX_W'(i))) begin
                r_mem[i] <= w_wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mux_sequencer
// Brief    : Steps an analog/digital multiplexer through a programmable table
//            of channels, staying on each entry for a programmable number of
//            accepted strobes, and tags each accepted sample with its channel
//            and a first-of-pass flag.
//            Optional feature macro: MUX_SEQ_DWELL_EN (per-entry dwell).
// Revision : 1.0 - initial release
// ============================================================================
module mux_sequencer
    import mux_seq_pkg::*;
#(
    parameter int num_channels = 5,
    parameter int select_width = 3,
    parameter int seq_depth    = 8,
    parameter int dwell_width  = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         strobe_in,
    input  logic                         cfg_we,
    input  logic [$clog2(seq_depth)-1:0] cfg_addr,
    input  logic [select_width-1:0]      cfg_sel,
    input  logic [dwell_width-1:0]       cfg_dwell,
    input  logic [$clog2(seq_depth)-1:0] seq_last,
    output logic [select_width-1:0]      select,
    output logic                         mux_enable,
    output logic                         strobe_out,
    output logic [select_width-1:0]      chan_out,
    output logic                         first_out,
    output logic                         busy,
    output logic                         cfg_err
);

    localparam int                  c_IDX_W  = $clog2(seq_depth);
    localparam logic [select_width:0] c_NUM_CH = (select_width + 1)'(num_channels);

    state_t                   r_state, w_state_nxt;
    logic [c_IDX_W-1:0]       r_index, w_index_nxt;
    logic [c_IDX_W-1:0]       r_seq_last, w_seq_last_nxt;
    logic [dwell_width-1:0]   r_dwell_cnt, w_dwell_nxt;
    logic [select_width-1:0]  r_select, w_select_nxt;
    logic                     r_strobe_out, w_strobe_nxt;
    logic [select_width-1:0]  r_chan_out, w_chan_nxt;
    logic                     r_first_out, w_first_nxt;
    logic                     r_cfg_err, w_cfg_err_nxt;

    logic                     w_sel_legal;
    logic                     w_cfg_ok;
    logic                     w_start;
    logic                     w_accept;
    logic                     w_advance;
    logic                     w_wrap;
    logic [c_IDX_W-1:0]       w_sel_addr;
    logic [dwell_width-1:0]   w_tbl_dwell;
    logic [select_width-1:0]  w_tbl_sel;

    // Configuration writes land only while idle and only for real channels.
    assign w_sel_legal   = ({1'b0, cfg_sel} < c_NUM_CH);
    assign w_cfg_ok      = enable & cfg_we & (r_state == ST_IDLE) & w_sel_legal;
    assign w_cfg_err_nxt = enable & cfg_we & ~((r_state == ST_IDLE) & w_sel_legal);

    // Stop beats start when both arrive together in IDLE.
    assign w_start   = enable & start & ~stop & (r_state == ST_IDLE);
    assign w_accept  = enable & strobe_in & (r_state != ST_IDLE);
    assign w_advance = w_accept & (r_dwell_cnt == w_tbl_dwell);
    assign w_wrap    = (r_index == r_seq_last);

    // The table select port looks at the entry that becomes current next:
    // entry 0 on start or wrap, else the following entry.
    assign w_sel_addr = (w_start || w_wrap) ? '0 : (r_index + 1'b1);

    mux_seq_table #(
        .SEL_W   (select_width),
        .DWELL_W (dwell_width),
        .DEPTH   (seq_depth),
        .IDX_W   (c_IDX_W)
    ) u_table (
        .clk          (clock),
        .rst          (reset),
        .i_we         (w_cfg_ok),
        .i_waddr      (cfg_addr),
        .i_wsel       (cfg_sel),
        .i_wdwell     (cfg_dwell),
        .i_dwell_addr (r_index),
        .i_sel_addr   (w_sel_addr),
        .o_dwell      (w_tbl_dwell),
        .o_sel        (w_tbl_sel)
    );

    // Next-state and datapath decisions; everything holds unless changed.
    always_comb begin
        w_state_nxt    = r_state;
        w_index_nxt    = r_index;
        w_seq_last_nxt = r_seq_last;
        w_dwell_nxt    = r_dwell_cnt;
        w_select_nxt   = r_select;
        w_strobe_nxt   = 1'b0;
        w_chan_nxt     = r_chan_out;
        w_first_nxt    = r_first_out;

        if (enable) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        w_state_nxt    = ST_RUN;
                        w_index_nxt    = '0;
                        w_dwell_nxt    = '0;
                        w_seq_last_nxt = seq_last;
                        w_select_nxt   = w_tbl_sel;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if ((r_state == ST_RUN) && stop) begin
                        w_state_nxt = ST_DRAIN;
                    end
                    if (w_accept) begin
                        w_strobe_nxt = 1'b1;
                        w_chan_nxt   = r_select;
                        w_first_nxt  = (r_index == '0) && (r_dwell_cnt == '0);
                        if (w_advance) begin
                            w_dwell_nxt  = '0;
                            w_index_nxt  = w_sel_addr;
                            w_select_nxt = w_tbl_sel;
                            // A draining pass ends on the wrap back to entry 0.
                            if (w_wrap && (r_state == ST_DRAIN)) begin
                                w_state_nxt = ST_IDLE;
                            end
                        end else begin
                            w_dwell_nxt = r_dwell_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; reset aborts any pass in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_index      <= '0;
            r_seq_last   <= '0;
            r_dwell_cnt  <= '0;
            r_select     <= '0;
            r_strobe_out <= 1'b0;
            r_chan_out   <= '0;
            r_first_out  <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_index      <= w_index_nxt;
            r_seq_last   <= w_seq_last_nxt;
            r_dwell_cnt  <= w_dwell_nxt;
            r_select     <= w_select_nxt;
            r_strobe_out <= w_strobe_nxt;
            r_chan_out   <= w_chan_nxt;
            r_first_out  <= w_first_nxt;
            r_cfg_err    <= w_cfg_err_nxt;
        end
    end

    assign select     = r_select;
    assign busy       = (r_state != ST_IDLE);
    assign mux_enable = busy & enable;
    assign strobe_out = r_strobe_out;
    assign chan_out   = r_chan_out;
    assign first_out  = r_first_out;
    assign cfg_err    = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_sequencer
// Brief    : Self-checking bench for mux_sequencer. Directed stimulus pushes
//            expected samples into a queue; a monitor pops and compares on
//            every strobe_out. Build with MUX_SEQ_DWELL_EN to cover dwell.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_sequencer;

    logic       clock = 1'b0;
    logic       reset, enable, start, stop, strobe_in, cfg_we;
    logic [2:0] cfg_addr, cfg_sel, seq_last;
    logic [7:0] cfg_dwell;
    logic [2:0] select, chan_out;
    logic       mux_enable, strobe_out, first_out, busy, cfg_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0] chan;
        logic       first;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    mux_sequencer #(
        .num_channels (5),
        .select_width (3),
        .seq_depth    (8),
        .dwell_width  (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .start      (start),
        .stop       (stop),
        .strobe_in  (strobe_in),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_sel    (cfg_sel),
        .cfg_dwell  (cfg_dwell),
        .seq_last   (seq_last),
        .select     (select),
        .mux_enable (mux_enable),
        .strobe_out (strobe_out),
        .chan_out   (chan_out),
        .first_out  (first_out),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [2:0] s, input logic [7:0] d);
        cfg_addr  = a;
        cfg_sel   = s;
        cfg_dwell = d;
        cfg_we    = 1'b1;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic go(input logic [2:0] last);
        seq_last = last;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic pulse_stop;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // One accepted strobe with its expected sample, then a quiet cycle.
    task automatic samp(input logic [2:0] ch, input logic f);
        exp_t e;
        e.chan  = ch;
        e.first = f;
        exp_q.push_back(e);
        strobe_in = 1'b1;
        tick();
        strobe_in = 1'b0;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_select"},     select,     0);
        chk({tag, "_mux_enable"}, mux_enable, 0);
        chk({tag, "_strobe_out"}, strobe_out, 0);
        chk({tag, "_chan_out"},   chan_out,   0);
        chk({tag, "_first_out"},  first_out,  0);
        chk({tag, "_busy"},       busy,       0);
        chk({tag, "_cfg_err"},    cfg_err,    0);
    endtask

    // Monitor: every accepted-sample pulse must match the next expectation.
    always @(negedge clock) begin
        if (strobe_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_sample: got chan %0d, expected no sample", chan_out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sample_chan",  chan_out,  mon_e.chan);
                chk("sample_first", first_out, mon_e.first);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; enable = 1'b1; start = 1'b0; stop = 1'b0;
        strobe_in = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_sel = '0;
        cfg_dwell = '0; seq_last = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Three-entry table {2,0,4}, seven samples, then drain.
        wr(3'd0, 3'd2, 8'd0);
        chk("legal_write_no_err", cfg_err, 0);
        wr(3'd1, 3'd0, 8'd0);
        wr(3'd2, 3'd4, 8'd0);
        go(3'd2);
        chk("run_busy", busy, 1);
        chk("run_mux_enable", mux_enable, 1);
        chk("start_select", select, 2);
        samp(3'd2, 1'b1); samp(3'd0, 1'b0); samp(3'd4, 1'b0);
        samp(3'd2, 1'b1); samp(3'd0, 1'b0); samp(3'd4, 1'b0);
        samp(3'd2, 1'b1);
        chk("select_after_7", select, 0);
        pulse_stop();
        chk("drain_busy", busy, 1);
        samp(3'd0, 1'b0);
        samp(3'd4, 1'b0);
        chk("drain_done_busy", busy, 0);

        // Stop after the second sample of a fresh pass.
        go(3'd2);
        samp(3'd2, 1'b1);
        samp(3'd0, 1'b0);
        pulse_stop();
        chk("stop_still_busy", busy, 1);
        samp(3'd4, 1'b0);
        chk("stop_idle_busy", busy, 0);
        chk("stop_idle_mux_enable", mux_enable, 0);
        strobe_in = 1'b1;
        tick();
        strobe_in = 1'b0;
        chk("idle_strobe_ignored", strobe_out, 0);
        tick();

        // Rejected writes: illegal channel in IDLE, any write while running.
        wr(3'd1, 3'd5, 8'd0);
        chk("bad_sel_err", cfg_err, 1);
        tick();
        chk("bad_sel_err_pulse", cfg_err, 0);
        go(3'd2);
        wr(3'd0, 3'd1, 8'd0);
        chk("run_write_err", cfg_err, 1);
        pulse_stop();
        samp(3'd2, 1'b1);
        samp(3'd0, 1'b0);
        samp(3'd4, 1'b0);
        chk("table_unchanged_idle", busy, 0);

        // Start and stop together in IDLE.
        seq_last = 3'd2;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_busy", busy, 0);
        chk("start_stop_mux_enable", mux_enable, 0);

        // Enable low freezes the sequencer.
        go(3'd2);
        samp(3'd2, 1'b1);
        chk("pre_freeze_select", select, 0);
        enable    = 1'b0;
        strobe_in = 1'b1;
        tick();
        chk("freeze_strobe_1", strobe_out, 0);
        chk("freeze_select", select, 0);
        strobe_in = 1'b0;
        tick();
        chk("freeze_strobe_2", strobe_out, 0);
        strobe_in = 1'b1;
        tick();
        chk("freeze_strobe_3", strobe_out, 0);
        chk("freeze_busy", busy, 1);
        chk("freeze_mux_enable", mux_enable, 0);
        strobe_in = 1'b0;
        enable    = 1'b1;
        tick();
        samp(3'd0, 1'b0);
        samp(3'd4, 1'b0);
        samp(3'd2, 1'b1);

        // Reset in the middle of a pass.
        reset     = 1'b1;
        strobe_in = 1'b1;
        tick();
        check_reset_outputs("midpass_reset");
        reset     = 1'b0;
        strobe_in = 1'b0;
        tick();

        // Dwell: entry0 sel1 dwell2, entry1 sel3 dwell0, two-entry pass.
        wr(3'd0, 3'd1, 8'd2);
        wr(3'd1, 3'd3, 8'd0);
        go(3'd1);
        chk("dwell_start_select", select, 1);
`ifdef MUX_SEQ_DWELL_EN
        samp(3'd1, 1'b1); samp(3'd1, 1'b0); samp(3'd1, 1'b0);
        samp(3'd3, 1'b0); samp(3'd1, 1'b1);
`else
        samp(3'd1, 1'b1); samp(3'd3, 1'b0); samp(3'd1, 1'b1);
        samp(3'd3, 1'b0); samp(3'd1, 1'b1);
`endif

        tick();
        tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
